// File: rtl/prbs_checker_if.sv
// ---------------------------------------------------------------------------
// prbs_checker_if
//
// Bundles the stimulus side of the PRBS checker: the byte-wide CH_CONFIG
// write bus and the received serial bit stream.
//
// Signals:
//   CH_CONFIG_WE    config write strobe, one cycle per byte
//   CH_CONFIG_ADDR  config register address (8 bits)
//   CH_CONFIG_DATA  config write data (8 bits)
//   rx_bit          received PRBS bit
//   rx_valid        qualifier for rx_bit
//
// Modports:
//   master  the side that drives config writes and the bit stream
//   slave   the checker, which only observes these signals
// ---------------------------------------------------------------------------
interface prbs_checker_if;
    logic       CH_CONFIG_WE;
    logic [7:0] CH_CONFIG_ADDR;
    logic [7:0] CH_CONFIG_DATA;
    logic       rx_bit;
    logic       rx_valid;

    modport master (
        output CH_CONFIG_WE,
        output CH_CONFIG_ADDR,
        output CH_CONFIG_DATA,
        output rx_bit,
        output rx_valid
    );

    modport slave (
        input CH_CONFIG_WE,
        input CH_CONFIG_ADDR,
        input CH_CONFIG_DATA,
        input rx_bit,
        input rx_valid
    );
endinterface

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//
// Receive-side PRBS checker. Self-synchronises a local LFSR to an incoming
// serial stream (SEED), then predicts every following bit and counts
// mismatches (CHECK). Too many errors inside one monitor window drops the
// checker back to SEED so it can reacquire the stream.
//
// Parameters:
//   WIN_LEN      lock-monitor window length in checked bits (power of 2)
//   LOSS_THRESH  errors within one window that force loss of lock
//   CNT_W        width of the saturating error and bit counters
//
// Ports:
//   dac_clk        sole clock, rising edge
//   reset_n        synchronous active-low reset
//   bus            prbs_checker_if.slave: CH_CONFIG write bus + rx_bit/rx_valid
//   locked         high while in CHECK
//   err_pulse      one-cycle pulse per mismatched bit
//   lock_lost      one-cycle pulse when the error threshold forces CHECK->SEED
//   err_count      saturating error count
//   bit_count      saturating count of checked bits
//   chk_state_dbg  00 IDLE, 01 SEED, 10 CHECK
//
// Config registers:
//   0x00  pn_order[2:0]  (0 PN3, 1 PN7, 2 PN9, 3 PN15, 4 PN23, 5 PN31, 6/7 PN7)
//   0x0A  bit0 enable, bit1 clear_counters (self-clearing, not stored)
//   0x0B  bit0 rx_invert, only when PRBS_CHK_INVERT_EN is defined
// ---------------------------------------------------------------------------
module prbs_checker #(
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic               dac_clk,
    input  logic               reset_n,
    prbs_checker_if.slave      bus,
    output logic               locked,
    output logic               err_pulse,
    output logic               lock_lost,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   bit_count,
    output logic [1:0]         chk_state_dbg
);
    localparam int WIN_W = $clog2(WIN_LEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEED  = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [4:0]       seed_cnt_q, seed_cnt_d;
    logic [WIN_W-1:0] win_bits_q, win_bits_d;
    logic [WIN_W-1:0] win_errs_q, win_errs_d;
    logic [CNT_W-1:0] err_count_d, bit_count_d;
    logic             err_pulse_d, lock_lost_d;

    logic [2:0]       pn_order_q;
    logic             enable_q;

    logic [4:0]       idx_n, idx_t;
    logic [31:0]      order_mask;
    logic             predicted;
    logic             rx_eff;
    logic             pn_wr;
    logic             clear_cmd;
    logic [31:0]      shifted;
    logic             mismatch;
    logic [WIN_W-1:0] win_errs_next;
    logic             unused_ok;

    // Write decode for the two registers whose writes have side effects
    // beyond storing a value: a pn_order write always resyncs, and the
    // clear bit of ctrl acts only in the cycle it is written.
    assign pn_wr     = bus.CH_CONFIG_WE && (bus.CH_CONFIG_ADDR == 8'h00);
    assign clear_cmd = bus.CH_CONFIG_WE && (bus.CH_CONFIG_ADDR == 8'h0A) && bus.CH_CONFIG_DATA[1];

    // Stored configuration: polynomial order and the enable bit.
    always_ff @(posedge dac_clk) begin
        if (!reset_n) begin
            pn_order_q <= 3'd0;
            enable_q   <= 1'b0;
        end else if (bus.CH_CONFIG_WE) begin
            if (bus.CH_CONFIG_ADDR == 8'h00) begin
                pn_order_q <= bus.CH_CONFIG_DATA[2:0];
            end
            if (bus.CH_CONFIG_ADDR == 8'h0A) begin
                enable_q <= bus.CH_CONFIG_DATA[0];
            end
        end
    end

`ifdef PRBS_CHK_INVERT_EN
    logic rx_invert_q;

    // Optional inversion for front ends that flip polarity; applied before
    // both seeding and comparison so the rest of the checker is unaware.
    always_ff @(posedge dac_clk) begin
        if (!reset_n) begin
            rx_invert_q <= 1'b0;
        end else if (bus.CH_CONFIG_WE && (bus.CH_CONFIG_ADDR == 8'h0B)) begin
            rx_invert_q <= bus.CH_CONFIG_DATA[0];
        end
    end

    assign rx_eff = bus.rx_bit ^ rx_invert_q;
`else
    assign rx_eff = bus.rx_bit;
`endif

    // Tap decode. Indices are stored as N-1 and T-1 so they can index the
    // LFSR directly and double as the final seed count.
    always_comb begin
        idx_n = 5'd6;
        idx_t = 5'd5;
        case (pn_order_q)
            3'd0: begin idx_n = 5'd2;  idx_t = 5'd1;  end
            3'd2: begin idx_n = 5'd8;  idx_t = 5'd4;  end
            3'd3: begin idx_n = 5'd14; idx_t = 5'd13; end
            3'd4: begin idx_n = 5'd22; idx_t = 5'd17; end
            3'd5: begin idx_n = 5'd30; idx_t = 5'd27; end
            default: begin idx_n = 5'd6; idx_t = 5'd5; end
        endcase
    end

    assign order_mask = (32'h2 << idx_n) - 32'h1;
    assign predicted  = lfsr_q[idx_n] ^ lfsr_q[idx_t];

    // Bit 31 of the LFSR is always masked off and the upper data bits carry
    // no register fields; folding them here keeps them visibly accounted for.
    assign unused_ok = ^{bus.CH_CONFIG_DATA[7:3], lfsr_q[31]};

    // Next-state logic. Disable and resync take priority over normal stream
    // processing. In CHECK the predicted bit, not the received one, is fed
    // back so a single flipped bit costs exactly one error. The clear
    // command is applied last so it overrides any increment in the same
    // cycle while leaving err_pulse intact.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        seed_cnt_d    = seed_cnt_q;
        win_bits_d    = win_bits_q;
        win_errs_d    = win_errs_q;
        err_count_d   = err_count;
        bit_count_d   = bit_count;
        err_pulse_d   = 1'b0;
        lock_lost_d   = 1'b0;
        shifted       = '0;
        mismatch      = 1'b0;
        win_errs_next = win_errs_q;

        if (!enable_q) begin
            state_d    = ST_IDLE;
            lfsr_d     = '0;
            seed_cnt_d = '0;
        end else if (pn_wr) begin
            state_d    = ST_SEED;
            lfsr_d     = '0;
            seed_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = '0;
                end
                ST_SEED: begin
                    if (bus.rx_valid) begin
                        shifted = {lfsr_q[30:0], rx_eff} & order_mask;
                        lfsr_d  = shifted;
                        if (seed_cnt_q == idx_n) begin
                            seed_cnt_d = '0;
                            if (shifted != '0) begin
                                state_d    = ST_CHECK;
                                win_bits_d = '0;
                                win_errs_d = '0;
                            end
                        end else begin
                            seed_cnt_d = seed_cnt_q + 5'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bus.rx_valid) begin
                        lfsr_d        = {lfsr_q[30:0], predicted} & order_mask;
                        mismatch      = rx_eff ^ predicted;
                        win_errs_next = win_errs_q + {{(WIN_W-1){1'b0}}, mismatch};
                        if (bit_count != {CNT_W{1'b1}}) begin
                            bit_count_d = bit_count + 1'b1;
                        end
                        if (mismatch) begin
                            err_pulse_d = 1'b1;
                            if (err_count != {CNT_W{1'b1}}) begin
                                err_count_d = err_count + 1'b1;
                            end
                        end
                        if (win_errs_next >= WIN_W'(LOSS_THRESH)) begin
                            state_d     = ST_SEED;
                            seed_cnt_d  = '0;
                            lock_lost_d = 1'b1;
                            win_bits_d  = '0;
                            win_errs_d  = '0;
                        end else if (win_bits_q == WIN_W'(WIN_LEN - 1)) begin
                            win_bits_d = '0;
                            win_errs_d = '0;
                        end else begin
                            win_bits_d = win_bits_q + 1'b1;
                            win_errs_d = win_errs_next;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (clear_cmd) begin
            err_count_d = '0;
            bit_count_d = '0;
            win_bits_d  = '0;
            win_errs_d  = '0;
        end
    end

    // State and datapath registers; reset returns everything to zero so
    // no pulse can be produced on a reset cycle.
    always_ff @(posedge dac_clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= '0;
            seed_cnt_q <= '0;
            win_bits_q <= '0;
            win_errs_q <= '0;
            err_count  <= '0;
            bit_count  <= '0;
            err_pulse  <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_cnt_q <= seed_cnt_d;
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
            err_count  <= err_count_d;
            bit_count  <= bit_count_d;
            err_pulse  <= err_pulse_d;
            lock_lost  <= lock_lost_d;
        end
    end

    assign locked        = (state_q == ST_CHECK);
    assign chk_state_dbg = state_q;
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the PRBS generator: consumes a serial bit stream, self-synchronises a local LFSR to it, then counts bit errors against the predicted sequence.
- Used in loopback and BIST paths, e.g. comparator or ADC slicer output back into the FPGA.
- Configured through the same byte-wide CH_CONFIG write bus, clocked on dac_clk.

Parameters:
- WIN_LEN, 64, lock-monitor window length in checked bits (power of 2, 8..1024).
- LOSS_THRESH, 8, errors within one window that force loss of lock (1..WIN_LEN).
- CNT_W, 32, width of error and bit counters.

Ports:
- dac_clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- CH_CONFIG_WE  in  1  config write strobe, one cycle per byte.
- CH_CONFIG_ADDR  in  8  config register address.
- CH_CONFIG_DATA  in  8  config write data.
- rx_bit  in  1  received PRBS bit.
- rx_valid  in  1  rx_bit qualifier; only valid cycles advance the checker.
- locked  out  1  high while in CHECK.
- err_pulse  out  1  one-cycle pulse per mismatched bit.
- lock_lost  out  1  one-cycle pulse on CHECK->SEED due to error threshold.
- err_count  out  CNT_W  saturating error count.
- bit_count  out  CNT_W  saturating count of checked bits (CHECK state only).
- chk_state_dbg  out  2  00 IDLE, 01 SEED, 10 CHECK.

Behaviour:
- Reset (reset_n=0 at edge): all outputs 0, state IDLE, LFSR=0, config regs 0.
- Config map:
  - 0x00 pn_order[2:0]: 0 PN3 x^3+x^2+1, 1 PN7 x^7+x^6+1, 2 PN9 x^9+x^5+1, 3 PN15 x^15+x^14+1, 4 PN23 x^23+x^18+1, 5 PN31 x^31+x^28+1; 6/7 decode as PN7.
  - 0x0A ctrl: bit0 enable; bit1 clear_counters, self-clearing, not stored.
  - Other addresses ignored.
- LFSR (32-bit s, polynomial x^N+x^T+1): predicted bit p = s[N-1]^s[T-1]. Each step s <= {s[30:0], b}, upper bits above N masked.
- FSM:
  - IDLE: enable=0. On enable=1 go to SEED, seed_cnt=0.
  - SEED: each rx_valid shifts rx_bit into s, seed_cnt++. When seed_cnt reaches N-1 on a valid, evaluate the post-shift state. If s[N-1:0] is nonzero, go to CHECK next cycle; if all-zero, seed_cnt=0 and stay in SEED.
  - CHECK: each rx_valid compares rx_bit with p and shifts in p, not rx_bit, so one flipped bit gives exactly one error. bit_count++ each valid. A mismatch causes err_pulse=1 and err_count++, both registered one cycle after the sampling edge.
  - Window: every WIN_LEN checked bits the window error count resets. If it reaches LOSS_THRESH, go to SEED, lock_lost=1 one cycle, locked=0. Counters are not cleared.
  - enable=0 in any state: IDLE next cycle, LFSR cleared, counters held.
- A pn_order write while enabled forces SEED (resync); a same-value write also resyncs.
- Counters saturate at all-ones, with no wrap.
- clear_counters zeroes err_count, bit_count and window count. If it coincides with an error or valid bit, clear wins: result is 0, but err_pulse still fires.
- rx_valid=0 cycles: no state change, no pulses.
- Reset asserted mid-stream: back to IDLE, config lost, no pulses on the reset cycle.

Optional Feature:
- PRBS_CHK_INVERT_EN defined: adds config register 0x0B bit0 rx_invert. When set, rx_bit is inverted before seeding and comparison, for inverting analog front ends. Reset value 0.
- Undefined: 0x0B ignored; no inversion logic present.

Test Plan:
- PN7 error-free: pn_order=1, enable=1, feed generator PN7 stream with seed 0x7F, rx_valid every cycle. Required: locked=1 by cycle 8 after first valid; after 1270 more bits err_count=0, bit_count=1270.
- Single error: PN7 locked; flip one bit. Required: exactly one err_pulse, err_count=1, locked stays 1, no lock_lost.
- Loss of lock: PN9 locked; feed constant 1 for 64 bits. Required: lock_lost pulse once err window hits 8. Reseed from constant 1: LFSR 0x1FF is a valid state, so relock with the mismatch repeating. Then return correct PN9: relock within 9 valids of the next loss.
- All-zero seed: enable, feed 40 zeros, PN15. Required: locked stays 0, state stays SEED, err_count=0.
- Clear/saturate collision: preload via long errors with CNT_W forced to 4 in a bench build. Required: err_count sticks at 15. Clear_counters on an error cycle gives err_count=0.
- Config resync and gapped valid: write pn_order=3 while locked. Required: locked=0 next cycle, relock after 15 valids; rx_valid at 1/3 duty produces identical counts.
